// File: rtl/hsi_pkg.sv
// Shared op codes, error codes, sequencer state type and the job config check
// for the hsi_vector_core sequencer.
package hsi_pkg;

    localparam logic [3:0] OP_CROSS    = 4'd1;
    localparam logic [3:0] OP_DOT      = 4'd2;

    localparam logic [3:0] ERR_NONE    = 4'd0;
    localparam logic [3:0] ERR_OP      = 4'd1;
    localparam logic [3:0] ERR_PIXELS  = 4'd5;
    localparam logic [3:0] ERR_TIMEOUT = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        RUN,
        DONE,
        ERR
    } seq_state_t;

    // Returns the error a job request would raise, or ERR_NONE if it can run.
    // Op/band problems take precedence over an empty pixel count.
    function automatic logic [3:0] cfg_error(
        input logic [3:0]  op,
        input logic [31:0] bands,
        input logic [31:0] pixels,
        input logic [31:0] comps_max
    );
        logic [3:0] e;
        e = ERR_NONE;
        if (op == OP_CROSS) begin
            if (bands != 32'd3) e = ERR_OP;
        end else if (op == OP_DOT) begin
            if (bands == 32'd0 || bands > comps_max) e = ERR_OP;
        end else begin
            e = ERR_OP;
        end
        if (e == ERR_NONE && pixels == 32'd0) e = ERR_PIXELS;
        return e;
    endfunction

endpackage

// File: rtl/hsi_result_stage.sv
// One-entry result register between the core output FIFO and the result
// stream. Tracks a read in flight (core data arrives one cycle after rd_en)
// and holds the captured word until the downstream accepts it.
module hsi_result_stage #(
    parameter int D = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_rd_en,
    input  logic [D-1:0] i_data,
    input  logic         i_last,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [D-1:0] o_data,
    output logic         o_last,
    output logic         o_busy,
    output logic         o_capture
);

    logic         r_inflight;
    logic         r_valid;
    logic         r_last;
    logic [D-1:0] r_data;

    // Capture core data the cycle after a read; release on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
        end else if (i_flush) begin
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_inflight <= i_rd_en;
            if (r_inflight) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
                r_last  <= i_last;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_last    = r_last;
    assign o_busy    = r_inflight || r_valid;
    assign o_capture = r_inflight && !i_flush;

endmodule

// File: rtl/hsi_core_sequencer.sv
// Job-level controller for hsi_vector_core: loads pixel pairs into the core
// input FIFOs in batches of up to FIFO_DEPTH, starts the core once per batch
// and drains its results onto a valid/ready stream.
module hsi_core_sequencer
    import hsi_pkg::*;
#(
    parameter int COMPONENT_WIDTH = 16,
    parameter int COMPONENTS_MAX  = 3,
    parameter int FIFO_DEPTH      = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int D = COMPONENT_WIDTH * COMPONENTS_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_start,
    input  logic [3:0]   cfg_op_code,
    input  logic [31:0]  cfg_num_bands,
    input  logic [31:0]  cfg_num_pixels,
    output logic         busy,
    output logic         done,
    output logic [3:0]   err_code,
    input  logic         src_valid,
    output logic         src_ready,
    input  logic [D-1:0] src_a_data,
    input  logic [D-1:0] src_b_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [D-1:0] res_data,
    output logic         res_last,
    output logic         core_in_wr_en,
    output logic [D-1:0] core_in1_data,
    output logic [D-1:0] core_in2_data,
    input  logic [1:0]   core_in_full,
    output logic         core_start,
    output logic [3:0]   core_op_code,
    output logic [31:0]  core_num_bands,
    input  logic [3:0]   core_error_code,
    output logic         core_out_rd_en,
    input  logic         core_out_empty,
    input  logic [D-1:0] core_out_data
);

    localparam int BW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] BATCH_MAX = BW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(TIMEOUT_CYCLES);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [3:0]    r_op;
    logic [31:0]   r_bands;
    logic [31:0]   r_pixels;
    logic [3:0]    r_err_code;
    logic [BW-1:0] r_batch_cnt;
    logic [31:0]   r_loaded;
    logic [31:0]   r_drained;
    logic [WW-1:0] r_wdog;
    logic [3:0]    w_cfg_err;
    logic          w_flush;
    logic          w_stage_busy;
    logic          w_capture;
    logic          w_last;

    assign w_cfg_err = cfg_error(cfg_op_code, cfg_num_bands, cfg_num_pixels, 32'(COMPONENTS_MAX));
    assign w_last    = (r_drained + 32'd1 == r_pixels);
    assign w_flush   = (w_next == ERR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and per-state handshake/strobe outputs.
    always_comb begin
        w_next         = r_state;
        src_ready      = 1'b0;
        core_in_wr_en  = 1'b0;
        core_start     = 1'b0;
        core_out_rd_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_start) w_next = (w_cfg_err == ERR_NONE) ? LOAD : ERR;
            end
            LOAD: begin
                src_ready     = !core_in_full[0] && !core_in_full[1] &&
                                (r_batch_cnt < BATCH_MAX) && (r_loaded < r_pixels);
                core_in_wr_en = src_valid && src_ready;
                // Counts are registered, so the batch closes the cycle after its last write.
                if (r_batch_cnt != '0 && (r_batch_cnt == BATCH_MAX || r_loaded == r_pixels))
                    w_next = KICK;
            end
            KICK: begin
                core_start = 1'b1;
                w_next     = RUN;
            end
            RUN: begin
                if (core_error_code != ERR_NONE || r_wdog >= WDOG_MAX) begin
                    w_next = ERR;
                end else begin
                    core_out_rd_en = !core_out_empty && !w_stage_busy;
                    if (r_drained == r_loaded && !w_stage_busy)
                        w_next = (r_loaded < r_pixels) ? LOAD : DONE;
                end
            end
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Job config latch, batch/pixel counters, watchdog and sticky error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_bands     <= '0;
            r_pixels    <= '0;
            r_err_code  <= ERR_NONE;
            r_batch_cnt <= '0;
            r_loaded    <= '0;
            r_drained   <= '0;
            r_wdog      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_op        <= cfg_op_code;
                        r_bands     <= cfg_num_bands;
                        r_pixels    <= cfg_num_pixels;
                        r_err_code  <= w_cfg_err;
                        r_batch_cnt <= '0;
                        r_loaded    <= '0;
                        r_drained   <= '0;
                        r_wdog      <= '0;
                    end
                end
                LOAD: begin
                    if (core_in_wr_en) begin
                        r_batch_cnt <= r_batch_cnt + BW'(1);
                        r_loaded    <= r_loaded + 32'd1;
                    end
                end
                KICK: r_wdog <= '0;
                RUN: begin
                    if (core_error_code != ERR_NONE) begin
                        r_err_code <= core_error_code;
                    end else if (r_wdog >= WDOG_MAX) begin
                        r_err_code <= ERR_TIMEOUT;
                    end else begin
                        if (w_capture) begin
                            r_drained <= r_drained + 32'd1;
                            r_wdog    <= '0;
                        end else begin
                            r_wdog <= r_wdog + WW'(1);
                        end
                        if (w_next != RUN) r_batch_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    hsi_result_stage #(.D(D)) u_result (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (w_flush),
        .i_rd_en   (core_out_rd_en),
        .i_data    (core_out_data),
        .i_last    (w_last),
        .i_ready   (res_ready),
        .o_valid   (res_valid),
        .o_data    (res_data),
        .o_last    (res_last),
        .o_busy    (w_stage_busy),
        .o_capture (w_capture)
    );

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign err_code       = r_err_code;
    assign core_in1_data  = src_a_data;
    assign core_in2_data  = src_b_data;
    assign core_op_code   = r_op;
    assign core_num_bands = r_bands;

endmodule

// File: tb/tb_hsi_core_sequencer.sv
// Scoreboard bench for hsi_core_sequencer with a behavioural core stub.
module tb_hsi_core_sequencer;

    localparam int CW = 16;
    localparam int CM = 3;
    localparam int FD = 16;
    localparam int TO = 1024;
    localparam int D  = CW * CM;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_start = 1'b0;
    logic [3:0]   cfg_op_code = '0;
    logic [31:0]  cfg_num_bands = '0;
    logic [31:0]  cfg_num_pixels = '0;
    logic         busy, done;
    logic [3:0]   err_code;
    logic         src_valid;
    logic         src_ready;
    logic [D-1:0] src_a_data, src_b_data;
    logic         res_valid;
    logic         res_ready;
    logic [D-1:0] res_data;
    logic         res_last;
    logic         core_in_wr_en;
    logic [D-1:0] core_in1_data, core_in2_data;
    logic [1:0]   core_in_full;
    logic         core_start;
    logic [3:0]   core_op_code;
    logic [31:0]  core_num_bands;
    logic [3:0]   core_error_code = '0;
    logic         core_out_rd_en;
    logic         core_out_empty;
    logic [D-1:0] core_out_data;

    always #5 clk = ~clk;

    hsi_core_sequencer #(
        .COMPONENT_WIDTH(CW), .COMPONENTS_MAX(CM), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_op_code(cfg_op_code),
        .cfg_num_bands(cfg_num_bands), .cfg_num_pixels(cfg_num_pixels),
        .busy(busy), .done(done), .err_code(err_code),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_a_data(src_a_data), .src_b_data(src_b_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_last(res_last),
        .core_in_wr_en(core_in_wr_en), .core_in1_data(core_in1_data),
        .core_in2_data(core_in2_data), .core_in_full(core_in_full),
        .core_start(core_start), .core_op_code(core_op_code),
        .core_num_bands(core_num_bands), .core_error_code(core_error_code),
        .core_out_rd_en(core_out_rd_en), .core_out_empty(core_out_empty),
        .core_out_data(core_out_data)
    );

    typedef struct { logic [D-1:0] a; logic [D-1:0] b; } pair_t;
    typedef struct { logic [D-1:0] data; logic last; } res_t;

    pair_t        srcq[$];
    res_t         expq[$];
    int           kickq[$];
    logic [D-1:0] inq_a[$], inq_b[$], outq[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    bit   stub_run = 1'b0;
    bit   stub_hang = 1'b0;
    bit   hold_low = 1'b0;
    bit   prev_stall = 1'b0;
    logic [D-1:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: cross product / dot product on signed components, truncated to CW bits.
    function automatic logic [D-1:0] model(input logic [3:0] op, input logic [31:0] bands,
                                           input logic [D-1:0] a, input logic [D-1:0] b);
        int x[3];
        int y[3];
        int acc;
        for (int i = 0; i < 3; i++) begin
            x[i] = int'($signed(a[16*i +: 16]));
            y[i] = int'($signed(b[16*i +: 16]));
        end
        if (op == 4'd1)
            return {16'(x[0]*y[1] - x[1]*y[0]), 16'(x[2]*y[0] - x[0]*y[2]), 16'(x[1]*y[2] - x[2]*y[1])};
        acc = 0;
        for (int i = 0; i < int'(bands); i++) acc += x[i] * y[i];
        return {32'd0, 16'(acc)};
    endfunction

    // Core stub: input FIFOs, processes queued pairs after start, output FIFO with 1-cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inq_a.delete();
            inq_b.delete();
            outq.delete();
            stub_run       <= 1'b0;
            core_out_data  <= '0;
            core_out_empty <= 1'b1;
            core_in_full   <= 2'b00;
        end else begin
            if (core_start) begin
                check("batch_size_at_start", inq_a.size(), (kickq.size() > 0) ? kickq.pop_front() : -1);
                stub_run <= 1'b1;
            end else if (stub_run && inq_a.size() == 0) begin
                stub_run <= 1'b0;
            end
            if (stub_run && inq_a.size() > 0) begin
                if (!stub_hang)
                    outq.push_back(model(core_op_code, core_num_bands, inq_a[0], inq_b[0]));
                inq_a.delete(0);
                inq_b.delete(0);
            end
            if (core_in_wr_en) begin
                inq_a.push_back(core_in1_data);
                inq_b.push_back(core_in2_data);
                wr_cnt <= wr_cnt + 1;
            end
            if (core_out_rd_en) begin
                if (outq.size() > 0) begin
                    core_out_data <= outq.pop_front();
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL core_rd_underflow: rd_en with empty output FIFO");
                end
            end
            core_out_empty <= (outq.size() == 0);
            core_in_full   <= {2{inq_a.size() >= FD}};
        end
    end

    // Result monitor: pops the scoreboard on each handshake, checks hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (prev_stall) check("res_hold_stable", {res_valid, res_data}, {1'b1, prev_data});
            if (res_valid && res_ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL res_unexpected: got %0h, expected no result", res_data);
                end else begin
                    res_t e;
                    e = expq.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_last", res_last, e.last);
                end
            end
            prev_stall <= res_valid && !res_ready;
            prev_data  <= res_data;
        end
    end

    // Source driver: randomly presents the next queued pair.
    initial begin
        bit    hs;
        pair_t p;
        src_valid  = 1'b0;
        src_a_data = '0;
        src_b_data = '0;
        forever begin
            @(posedge clk);
            hs = src_valid && src_ready && rst_n;
            #1;
            if (hs && srcq.size() > 0) p = srcq.pop_front();
            if (srcq.size() > 0 && ($urandom % 4 != 0)) begin
                src_valid  = 1'b1;
                src_a_data = srcq[0].a;
                src_b_data = srcq[0].b;
            end else begin
                src_valid = 1'b0;
            end
        end
    end

    // Downstream ready: random backpressure, or held low on request.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            res_ready = hold_low ? 1'b0 : ($urandom % 3 != 0);
        end
    end

    // pat: -1 no data, 0 random, 1 fixed dot pair, 2 fixed cross pair.
    task automatic run_job(input logic [3:0] op, input logic [31:0] bands, input logic [31:0] pix,
                           input int pat, input bit push_exp, input logic [3:0] exp_err,
                           input int limit, output int cyc);
        logic [D-1:0] a, b, e;
        int d0, w0, rem;
        if (pat >= 0) begin
            for (int i = 0; i < int'(pix); i++) begin
                case (pat)
                    1: begin
                        a = {16'd3, 16'd2, 16'd1};
                        b = {16'd6, 16'd5, 16'd4};
                        e = {32'd0, 16'd32};
                    end
                    2: begin
                        a = {32'd0, 16'd1};
                        b = {16'd0, 16'd1, 16'd0};
                        e = {16'd1, 32'd0};
                    end
                    default: begin
                        a = {16'($urandom), 16'($urandom), 16'($urandom)};
                        b = {16'($urandom), 16'($urandom), 16'($urandom)};
                        e = model(op, bands, a, b);
                    end
                endcase
                srcq.push_back('{a, b});
                if (push_exp) expq.push_back('{e, (i == int'(pix) - 1)});
            end
            rem = int'(pix);
            while (rem > 0) begin
                kickq.push_back((rem > FD) ? FD : rem);
                rem -= FD;
            end
        end
        d0 = done_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        cfg_start      = 1'b1;
        cfg_op_code    = op;
        cfg_num_bands  = bands;
        cfg_num_pixels = pix;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cyc = 0;
        while (busy && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("job_ends_busy_low", busy, 1'b0);
        @(negedge clk);
        check("err_code", err_code, exp_err);
        check("done_pulses", done_cnt - d0, (exp_err == 4'd0) ? 1 : 0);
        if (exp_err == 4'd0) begin
            check("results_outstanding", expq.size(), 0);
            check("starts_outstanding", kickq.size(), 0);
        end
        if (pat < 0) check("no_core_writes", wr_cnt - w0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err_code", err_code, 4'd0);
        check("rst_src_ready", src_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_core_ctrl", {core_start, core_in_wr_en, core_out_rd_en}, 3'b000);
        check("rst_core_op", core_op_code, 4'd0);
        srcq.delete();
        expq.delete();
        kickq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        logic [3:0] op;
        logic [31:0] bands;

        do_reset();
        repeat (2) @(posedge clk);

        // Single dot product, then a two-batch cross job.
        run_job(4'd2, 32'd3, 32'd1, 1, 1'b1, 4'd0, 500, cyc);
        run_job(4'd1, 32'd3, 32'd20, 2, 1'b1, 4'd0, 2000, cyc);

        // Random jobs across batch boundaries.
        for (int j = 0; j < 4; j++) begin
            op    = ($urandom % 2 == 0) ? 4'd1 : 4'd2;
            bands = (op == 4'd1) ? 32'd3 : 32'(1 + $urandom % 3);
            run_job(op, bands, 32'(1 + $urandom % 40), 0, 1'b1, 4'd0, 3000, cyc);
        end

        // Backpressure: res_ready held low for 50 cycles mid-job.
        fork
            run_job(4'd1, 32'd3, 32'd20, 0, 1'b1, 4'd0, 3000, cyc);
            begin
                repeat (40) @(posedge clk);
                #1;
                hold_low = 1'b1;
                repeat (50) @(posedge clk);
                #1;
                hold_low = 1'b0;
            end
        join

        // Rejected configurations.
        run_job(4'd1, 32'd2, 32'd5, -1, 1'b0, 4'd1, 10, cyc);
        check("cfg_err_latency", (cyc <= 1), 1'b1);
        run_job(4'd2, 32'd0, 32'd5, -1, 1'b0, 4'd1, 10, cyc);
        run_job(4'd2, 32'd4, 32'd5, -1, 1'b0, 4'd1, 10, cyc);
        run_job(4'd3, 32'd3, 32'd5, -1, 1'b0, 4'd1, 10, cyc);
        run_job(4'd2, 32'd3, 32'd0, -1, 1'b0, 4'd5, 10, cyc);
        check("cfg_err_latency_pixels", (cyc <= 1), 1'b1);

        // A good job after an error clears err_code.
        run_job(4'd2, 32'd2, 32'd3, 0, 1'b1, 4'd0, 500, cyc);

        // Core never answers: watchdog.
        stub_hang = 1'b1;
        run_job(4'd1, 32'd3, 32'd4, 0, 1'b0, 4'd8, TO + 500, cyc);
        check("timeout_not_early", (cyc >= TO), 1'b1);

        // Core reports an error while running.
        core_error_code = 4'd3;
        run_job(4'd1, 32'd3, 32'd2, 0, 1'b0, 4'd3, 500, cyc);
        core_error_code = 4'd0;
        stub_hang = 1'b0;

        // Reset in the middle of LOAD, then a clean job.
        for (int i = 0; i < 20; i++)
            srcq.push_back('{48'(i), 48'(i + 1)});
        @(posedge clk);
        #1;
        cfg_start = 1'b1; cfg_op_code = 4'd1; cfg_num_bands = 32'd3; cfg_num_pixels = 32'd20;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        repeat (6) @(posedge clk);
        check("mid_load_busy", busy, 1'b1);
        do_reset();
        repeat (2) @(posedge clk);
        run_job(4'd1, 32'd3, 32'd18, 0, 1'b1, 4'd0, 3000, cyc);

        check("final_results_outstanding", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
